// File: rtl/phaser_axil_regbank.sv
// phaser_axil_regbank: AXI4-Lite slave register bank with byte strobes, RO status slots and per-register write pulses.
// Optional macro PHASER_REGBANK_SLVERR_EN: SLVERR on illegal writes and out-of-range reads (OKAY everywhere otherwise).
module phaser_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 8,
  parameter int NUM_RO             = 2
) (
  input  logic                                   s00_axi_aclk,
  input  logic                                   s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
  input  logic [2:0]                             s00_axi_awprot,
  input  logic                                   s00_axi_awvalid,
  output logic                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
  input  logic                                   s00_axi_wvalid,
  output logic                                   s00_axi_wready,
  output logic [1:0]                             s00_axi_bresp,
  output logic                                   s00_axi_bvalid,
  input  logic                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
  input  logic [2:0]                             s00_axi_arprot,
  input  logic                                   s00_axi_arvalid,
  output logic                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
  output logic [1:0]                             s00_axi_rresp,
  output logic                                   s00_axi_rvalid,
  input  logic                                   s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int NB       = DW / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int IDX_W    = AW - ADDR_LSB;
  localparam int NUM_RW   = NUM_REGS - NUM_RO;
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;
  localparam logic [31:0] NUM_RW_U   = NUM_RW;
  localparam logic [1:0]  RESP_OK    = 2'b00;
`ifdef PHASER_REGBANK_SLVERR_EN
  localparam logic [1:0]  RESP_ERR   = 2'b10;
`else
  localparam logic [1:0]  RESP_ERR   = 2'b00;
`endif

  logic             r_aw_held;
  logic             r_w_held;
  logic [IDX_W-1:0] r_aw_idx;
  logic [DW-1:0]    r_w_data;
  logic [NB-1:0]    r_w_strb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic             r_rvalid;
  logic [1:0]       r_rresp;
  logic [DW-1:0]    r_rdata;
  logic [DW-1:0]    r_regs [NUM_RW];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic             w_commit;
  logic             w_aw_rw;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_ar_inrange;
  logic [DW-1:0]    w_rd_data;
  logic             w_unused;

  assign w_commit     = r_aw_held && r_w_held && !r_bvalid;
  assign w_aw_rw      = 32'(r_aw_idx) < NUM_RW_U;
  assign w_ar_idx     = s00_axi_araddr[AW-1:ADDR_LSB];
  assign w_ar_inrange = 32'(w_ar_idx) < NUM_REGS_U;
  assign w_unused     = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

  assign s00_axi_awready = !r_aw_held;
  assign s00_axi_wready  = !r_w_held;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = r_bresp;
  assign s00_axi_arready = !r_rvalid;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rresp   = r_rresp;
  assign s00_axi_rdata   = r_rdata;
  assign wr_pulse        = r_wr_pulse;

  // Commit stalls while a response is outstanding, so each held pair is buffered at most once.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OK;
      r_wr_pulse <= '0;
      for (int k = 0; k < NUM_RW; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (s00_axi_awvalid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s00_axi_awaddr[AW-1:ADDR_LSB];
      end
      if (s00_axi_wvalid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_w_data <= s00_axi_wdata;
        r_w_strb <= s00_axi_wstrb;
      end
      if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_rw ? RESP_OK : RESP_ERR;
        for (int k = 0; k < NUM_RW; k++) begin
          if (r_aw_idx == IDX_W'(k)) begin
            r_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < NB; b++)
              if (r_w_strb[b]) r_regs[k][b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // RO slots return the live status input; reads see pre-commit register contents.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_RW; k++)
      if (w_ar_idx == IDX_W'(k)) w_rd_data = r_regs[k];
    for (int j = 0; j < NUM_RO; j++)
      if (w_ar_idx == IDX_W'(NUM_RW + j)) w_rd_data = ro_in[j*DW +: DW];
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OK;
      r_rdata  <= '0;
    end else begin
      if (r_rvalid && s00_axi_rready) r_rvalid <= 1'b0;
      if (s00_axi_arvalid && !r_rvalid) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_ar_inrange ? RESP_OK : RESP_ERR;
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < NUM_RW; k++) reg_out[k*DW +: DW] = r_regs[k];
  end

endmodule

// File: tb/tb_phaser_axil_regbank.sv
// Directed bench for phaser_axil_regbank (default parameters) with response scoreboards.
module tb_phaser_axil_regbank;
  localparam logic [1:0] OK = 2'b00;
`ifdef PHASER_REGBANK_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [5:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [255:0] reg_out;
  logic [63:0] ro_in;
  logic [7:0]  wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt [8] = '{default: 0};
  int exp_cnt   [8] = '{default: 0};
  logic [1:0] wr_q [$];
  rd_exp_t    rd_q [$];

  phaser_axil_regbank dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    for (int k = 0; k < 8; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_slot(input int k);
    return reg_out[k*32 +: 32];
  endfunction

  task automatic note_pulse(input logic [7:0] pulse);
    for (int k = 0; k < 8; k++) if (pulse[k]) exp_cnt[k]++;
  endtask

  // Called at the negedge after the address/data beats were accepted.
  task automatic wait_b(input string tag, input logic [7:0] pulse, input int lat);
    int n = 0;
    logic [1:0] e;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_blat"}, 64'(n), 64'(lat));
    chk({tag, "_pulse"}, 64'(wr_pulse), 64'(pulse));
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    if (bvalid && wr_q.size() > 0) begin
      e = wr_q.pop_front();
      chk({tag, "_bresp"}, 64'(bresp), 64'(e));
    end
  endtask

  task automatic axi_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input logic [7:0] pulse);
    int  n = 0;
    bit  aw_pend = 1'b1, w_pend = 1'b1, aw_fire, w_fire;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    wr_q.push_back(resp);
    note_pulse(pulse);
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge clk);
      if (aw_fire) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin wvalid  = 1'b0; w_pend  = 1'b0; end
      n++;
    end
    chk({tag, "_accept_timeout"}, 64'({aw_pend, w_pend}), 64'd0);
    wait_b(tag, pulse, 1);
  endtask

  task automatic axi_read(input string tag, input logic [5:0] addr, input logic [31:0] data,
                          input logic [1:0] resp);
    int n = 0;
    bit pend = 1'b1, fire;
    rd_exp_t e;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    e.data = data; e.resp = resp;
    rd_q.push_back(e);
    while (pend && n < 20) begin
      fire = arvalid && arready;
      @(negedge clk);
      if (fire) begin arvalid = 1'b0; pend = 1'b0; end
      n++;
    end
    chk({tag, "_ar_timeout"}, 64'(pend), 64'd0);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rlat"}, 64'(n), 64'd0);
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    if (rvalid && rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk({tag, "_rdata"}, 64'(rdata), 64'(e.data));
      chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
    end
  endtask

  initial begin
    rd_exp_t    re;
    logic [1:0] be;
    rst_n = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    ro_in = {32'h0BADF00D, 32'hDEADBEEF};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) chk("rst_reg_out", 64'(reg_slot(k)), 64'd0);
    chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    axi_read("rd_rst0", 6'h00, 32'h0, OK);

    axi_write("wr0", 6'h00, 32'h1, 4'hF, OK, 8'h01);
    axi_write("wr1", 6'h04, 32'h2, 4'hF, OK, 8'h02);
    axi_write("wr2", 6'h08, 32'h3, 4'hF, OK, 8'h04);
    axi_write("wr3", 6'h0C, 32'h4, 4'hF, OK, 8'h08);
    for (int k = 0; k < 4; k++) chk("reg_out_wr", 64'(reg_slot(k)), 64'(k + 1));
    axi_read("rd0", 6'h00, 32'h1, OK);
    axi_read("rd1", 6'h04, 32'h2, OK);
    axi_read("rd2", 6'h08, 32'h3, OK);
    axi_read("rd3", 6'h0C, 32'h4, OK);
    for (int k = 0; k < 4; k++) chk("pulse_once", 64'(pulse_cnt[k]), 64'(exp_cnt[k]));

    axi_write("strb_full", 6'h00, 32'h00000001, 4'hF, OK, 8'h01);
    axi_write("strb_b1", 6'h00, 32'hAABBCCDD, 4'b0010, OK, 8'h01);
    axi_read("rd_strb", 6'h00, 32'h0000CC01, OK);
    axi_write("strb_zero", 6'h0C, 32'hFFFFFFFF, 4'b0000, OK, 8'h08);
    axi_read("rd_strb0", 6'h0C, 32'h4, OK);

    // W three cycles ahead of AW, response stalled, second pair buffered behind it.
    @(negedge clk);
    bready = 1'b0; wdata = 32'h5555AAAA; wstrb = 4'hF; wvalid = 1'b1;
    chk("st_wready", 64'(wready), 64'd1);
    @(negedge clk); wvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    awaddr = 6'h04; awvalid = 1'b1; wr_q.push_back(OK); note_pulse(8'h02);
    chk("st_awready", 64'(awready), 64'd1);
    @(negedge clk); awvalid = 1'b0;
    chk("st_no_early_b", 64'(bvalid), 64'd0);
    @(negedge clk);
    chk("st_b1", 64'(bvalid), 64'd1);
    chk("st_pulse1", 64'(wr_pulse), 64'h02);
    awaddr = 6'h08; awvalid = 1'b1; wdata = 32'hCAFE0002; wvalid = 1'b1; wr_q.push_back(OK); note_pulse(8'h04);
    chk("st_aw2_ready", 64'(awready), 64'd1);
    chk("st_w2_ready", 64'(wready), 64'd1);
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_hold_bvalid", 64'(bvalid), 64'd1);
      chk("st_hold_bresp", 64'(bresp), 64'(wr_q[0]));
      chk("st_third_awready", 64'(awready), 64'd0);
      chk("st_third_wready", 64'(wready), 64'd0);
      chk("st_reg2_old", 64'(reg_slot(2)), 64'h3);
      chk("st_no_pulse", 64'(wr_pulse), 64'd0);
      @(negedge clk);
    end
    bready = 1'b1;
    be = wr_q.pop_front();
    chk("st_bresp1", 64'(bresp), 64'(be));
    @(negedge clk);
    wait_b("st2", 8'h04, 1);
    chk("st_reg1", 64'(reg_slot(1)), 64'h5555AAAA);
    chk("st_reg2", 64'(reg_slot(2)), 64'hCAFE0002);

    // rdata stays stable while rready is low.
    @(negedge clk);
    rready = 1'b0; araddr = 6'h04; arvalid = 1'b1;
    re.data = 32'h5555AAAA; re.resp = OK; rd_q.push_back(re);
    @(negedge clk); arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rs_rvalid", 64'(rvalid), 64'd1);
      chk("rs_rdata", 64'(rdata), 64'(re.data));
      chk("rs_arready", 64'(arready), 64'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    re = rd_q.pop_front();
    chk("rs_rdata_pop", 64'(rdata), 64'(re.data));
    chk("rs_rresp_pop", 64'(rresp), 64'(re.resp));
    @(negedge clk);
    chk("rs_rvalid_clr", 64'(rvalid), 64'd0);

    axi_write("ro_wr", 6'h18, 32'h12345678, 4'hF, ERR, 8'h00);
    chk("ro_reg_out", 64'(reg_slot(6)), 64'd0);
    axi_read("ro_rd0", 6'h18, 32'hDEADBEEF, OK);
    axi_read("ro_rd1", 6'h1C, 32'h0BADF00D, OK);
    ro_in[31:0] = 32'h13572468;
    axi_read("ro_live", 6'h18, 32'h13572468, OK);
    axi_read("oor_rd", 6'h20, 32'h0, ERR);
    axi_write("oor_wr", 6'h24, 32'hFFFFFFFF, 4'hF, ERR, 8'h00);
    for (int k = 0; k < 8; k++) chk("pulse_total", 64'(pulse_cnt[k]), 64'(exp_cnt[k]));

    // Reset between beat capture and commit drops the write without a response.
    @(negedge clk);
    awaddr = 6'h00; awvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_bvalid", 64'(bvalid), 64'd0);
      chk("mr_reg0", 64'(reg_slot(0)), 64'd0);
      chk("mr_awready", 64'(awready), 64'd1);
    end
    for (int k = 0; k < 8; k++) chk("mr_pulse_total", 64'(pulse_cnt[k]), 64'(exp_cnt[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/phaser_axil_regbank.md
# phaser_axil_regbank

Parametrised AXI4-Lite slave register bank for the phaser IP. It generalises the fixed four-register S00_AXI interface to NUM_REGS registers of configurable width, adding byte-lane strobes, read-only status registers fed from the datapath, per-register write pulses and decode-error handling. It sits between the AXI interconnect and the phaser datapath: control registers drive the datapath, and status registers sample it.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; must be 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; must satisfy 2^C_S_AXI_ADDR_WIDTH ≥ NUM_REGS·(DW/8).
- NUM_REGS, 8: total registers, 2..64.
- NUM_RO, 2: the top NUM_RO indices are read-only; range 0..NUM_REGS-1.

Ports:
- s00_axi_aclk  in  1  clock; all logic on rising edge.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr/awprot/awvalid/awready  AXI4-Lite write-address channel.
- s00_axi_wdata/wstrb/wvalid/wready  write-data channel (wstrb DW/8).
- s00_axi_bresp/bvalid/bready  write-response channel.
- s00_axi_araddr/arprot/arvalid/arready  read-address channel.
- s00_axi_rdata/rresp/rvalid/rready  read-data channel.
- reg_out  out  NUM_REGS·DW  flat register contents; register k at [k·DW +: DW]; RO slots are driven 0.
- ro_in  in  NUM_RO·DW  status inputs; RO slot j maps to register NUM_REGS-NUM_RO+j.
- wr_pulse  out  NUM_REGS  one-cycle strobe per register, asserted in the cycle a write commits.

## Operation
- Decode: index = addr[ADDR_W-1:ADDR_LSB], where ADDR_LSB = clog2(DW/8). An address with index ≥ NUM_REGS is out of range. Low address bits and prot are ignored.
- Write path:
  - The AW and W beats are captured independently into holding registers aw_held and w_held.
  - awready = !aw_held; wready = !w_held.
  - Commit happens when aw_held && w_held && !bvalid.
    - For an in-range RW index, update the bytes selected by wstrb and pulse wr_pulse[index].
    - For an RO or out-of-range index, nothing is written and no pulse is issued.
  - After commit, both held flags clear and bvalid is set. bvalid holds until bready.
- Read path:
  - arready = !rvalid.
  - On handshake, rdata is registered from the current value. RW slots return the register; RO slots return ro_in sampled at the handshake edge; out-of-range returns 0.
  - rvalid holds, with rdata stable, until rready.
- Write and read channels are fully independent.
- A simultaneous read handshake and commit to the same index returns the pre-write value.
- wstrb = 0 commits with no data change but still pulses wr_pulse and returns a response.

## Timing
- Reset (asynchronous assert, synchronous deassert seen by the flops): all registers 0, reg_out 0, wr_pulse 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, held flags 0. awready/wready/arready are 1 one cycle after reset release.
- Reset mid-transaction aborts it; no response is issued.
- Write latency:
  - AW and W in cycle 0 → commit edge of cycle 1, with reg_out and wr_pulse updated in cycle 2 (reg_out from cycle 2 onward, wr_pulse for cycle 2 only) → bvalid in cycle 2.
  - If W arrives N cycles after AW, all events shift by N.
- Read latency: ar handshake in cycle 0 → rvalid in cycle 1.
- Throughput:
  - With bready tied high, one write every 2 cycles.
  - With rready tied high, one read every 2 cycles.
  - While bvalid is stalled, one extra AW and W may be buffered; further beats see ready low.

## Configuration
- PHASER_REGBANK_SLVERR_EN defined: writes to RO or out-of-range indices, and reads from out-of-range indices, return resp 2'b10 (SLVERR). Read data is still 0.
- Not defined: every response is 2'b00 (OKAY). Illegal writes are silently dropped and out-of-range reads return 0.

## Test plan
- Reset release → all reg_out 0. Read index 0 returns 0x00000000, OKAY. ready signals are high in the cycle after release.
- Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read them back → 0x1..0x4 with OKAY. Each write produces exactly one wr_pulse on its index, in the cycle after the commit edge.
- Write 0x00000001 to 0x0, then 0xAABBCCDD with wstrb 4'b0010 → readback 0x0000CC01.
- W presented 3 cycles before AW, with bready low for 5 cycles → single commit, bvalid held stable. A second AW/W is accepted once; a third sees awready=0 until bready.
- ro_in slot 0 = 0xDEADBEEF; write 0x12345678 to RO address 0x18 and read 0x18 → 0xDEADBEEF, no wr_pulse. bresp is 2'b10 with the macro and 2'b00 without.
- Read address 0x20 (index 8, out of range) → rdata 0. rresp is 2'b10 with the macro and 2'b00 without.
